// File: rtl/wavelet_pkg.sv
// Shared definitions for the 5/3 wavelet line queues (forward and inverse).
// Holds coefficient/address widths, the line length, the three-state line
// sequencer encoding and a sign-extension helper for the lifting arithmetic.
package wavelet_pkg;

    localparam int unsigned COEF_W     = 16;  // coefficient / sample width
    localparam int unsigned INT_W      = 18;  // lifting intermediate width
    localparam int unsigned LINE_PAIRS = 8;   // coefficient pairs per line
    localparam int unsigned ADDR_W     = 12;  // {line, column}
    localparam int unsigned LINE_W     = 8;
    localparam int unsigned COL_W      = ADDR_W - LINE_W;

    typedef enum logic [1:0] {
        StFirst,
        StRun,
        StFlush
    } wq_state_e;

    function automatic logic signed [INT_W-1:0] sext(input logic signed [COEF_W-1:0] v);
        return {{(INT_W - COEF_W){v[COEF_W-1]}}, v};
    endfunction

endpackage

// File: rtl/inv_lift_53.sv
// Combinational integer 5/3 inverse lifting update.
// Ports:
//   s, d        - incoming low/high coefficient pair n
//   d_left      - d[n-1] used for the even update (d[0] itself at the left edge)
//   d_prev      - d[n-1] used for the odd update of pair n-1
//   x_prev      - x[2n-2], the stored even sample of pair n-1
//   right_edge  - mirror x[2n] = x[2n-2] for the last pair of a line
//   x_even      - x[2n]
//   x_odd       - x[2n-1]
module inv_lift_53
    import wavelet_pkg::*;
(
    input  logic signed [COEF_W-1:0] s,
    input  logic signed [COEF_W-1:0] d,
    input  logic signed [COEF_W-1:0] d_left,
    input  logic signed [COEF_W-1:0] d_prev,
    input  logic signed [COEF_W-1:0] x_prev,
    input  logic                     right_edge,
    output logic signed [COEF_W-1:0] x_even,
    output logic signed [COEF_W-1:0] x_odd
);

    logic signed [INT_W-1:0] sum_d;
    logic signed [INT_W-1:0] x_even_w;
    logic signed [INT_W-1:0] x_next;
    logic signed [INT_W-1:0] sum_x;
    logic signed [INT_W-1:0] x_odd_w;

    always_comb begin
        sum_d    = sext(d_left) + sext(d) + 18'sd2;
        x_even_w = sext(s) - (sum_d >>> 2);
        x_even   = COEF_W'(x_even_w);
        // Feed the truncated even sample forward, as it will be stored.
        x_next   = right_edge ? sext(x_prev) : sext(x_even);
        sum_x    = sext(x_prev) + x_next;
        x_odd_w  = sext(d_prev) + (sum_x >>> 1);
        x_odd    = COEF_W'(x_odd_w);
    end

endmodule

// File: rtl/inv_wavelet_queue.sv
// Line-based 5/3 inverse wavelet queue. Accepts one (s[n], d[n]) pair per
// cycle and emits reconstructed (x[2n], x[2n+1]) pairs one pair behind, with
// a single flush cycle after the last pair of each line. Never stalls.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   wrreq                   - input pair valid
//   data_in_low/high        - s[n], d[n] (signed)
//   line_address            - line index, sampled with pair 0
//   output_valid            - reconstructed pair valid (one cycle per pair)
//   data_out_even/odd       - x[2n], x[2n+1] (signed)
//   even_address/odd_address- {line, column}
module inv_wavelet_queue
    import wavelet_pkg::*;
#(
    parameter int unsigned LINE_PAIRS = wavelet_pkg::LINE_PAIRS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrreq,
    input  logic signed [COEF_W-1:0] data_in_low,
    input  logic signed [COEF_W-1:0] data_in_high,
    input  logic [LINE_W-1:0]        line_address,
    output logic                     output_valid,
    output logic signed [COEF_W-1:0] data_out_even,
    output logic signed [COEF_W-1:0] data_out_odd,
    output logic [ADDR_W-1:0]        even_address,
    output logic [ADDR_W-1:0]        odd_address
);

    localparam int unsigned CNT_W = COL_W - 1;

    wq_state_e                state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         pair_idx;
    logic [LINE_W-1:0]        line_q;
    logic signed [COEF_W-1:0] prev_d_q;
    logic signed [COEF_W-1:0] prev_x_q;
    logic signed [COEF_W-1:0] d_left;
    logic signed [COEF_W-1:0] x_even;
    logic signed [COEF_W-1:0] x_odd;
    logic                     in_flush;
    logic                     emit;

    assign in_flush = (state_q == StFlush);
    assign emit     = in_flush || (state_q == StRun && wrreq);
    // Outside RUN the incoming pair is pair 0, so d[-1] mirrors to d[0].
    assign d_left   = (state_q == StRun) ? prev_d_q : data_in_high;
    assign pair_idx = in_flush ? CNT_W'(LINE_PAIRS - 1) : cnt_q - CNT_W'(1);

    inv_lift_53 u_lift (
        .s          (data_in_low),
        .d          (data_in_high),
        .d_left     (d_left),
        .d_prev     (prev_d_q),
        .x_prev     (prev_x_q),
        .right_edge (in_flush),
        .x_even     (x_even),
        .x_odd      (x_odd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFirst;
            cnt_q         <= '0;
            line_q        <= '0;
            prev_d_q      <= '0;
            prev_x_q      <= '0;
            output_valid  <= 1'b0;
            data_out_even <= '0;
            data_out_odd  <= '0;
            even_address  <= '0;
            odd_address   <= '0;
        end else begin
            output_valid <= 1'b0;
            // line_q is read before a same-cycle pair 0 overwrites it.
            if (emit) begin
                output_valid  <= 1'b1;
                data_out_even <= prev_x_q;
                data_out_odd  <= x_odd;
                even_address  <= {line_q, pair_idx, 1'b0};
                odd_address   <= {line_q, pair_idx, 1'b1};
            end
            unique case (state_q)
                StFirst, StFlush: begin
                    if (wrreq) begin
                        prev_x_q <= x_even;
                        prev_d_q <= data_in_high;
                        line_q   <= line_address;
                        cnt_q    <= CNT_W'(1);
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StFirst;
                    end
                end
                StRun: begin
                    if (wrreq) begin
                        prev_x_q <= x_even;
                        prev_d_q <= data_in_high;
                        if (cnt_q == CNT_W'(LINE_PAIRS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StFlush;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= StFirst;
            endcase
        end
    end

endmodule

// File: doc/inv_wavelet_queue.md
INV_WAVELET_QUEUE -- requirements
Module: inv_wavelet_queue

Interface
REQ-001 SHALL take clock clk; reset rst_n, synchronous, active-low.
REQ-002 SHALL have these ports, name direction width meaning:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wrreq  in  1  input coefficient pair valid this cycle.
- data_in_low  in  16  low-band coefficient s[n], signed.
- data_in_high  in  16  high-band coefficient d[n], signed.
- line_address  in  8  line index; sampled with pair 0 of each line.
- output_valid  out  1  reconstructed pair valid this cycle.
- data_out_even  out  16  sample x[2n], signed.
- data_out_odd  out  16  sample x[2n+1], signed.
- even_address  out  12  {line, 4-bit column 2n}.
- odd_address  out  12  {line, 4-bit column 2n+1}.
REQ-003 SHALL have parameter LINE_PAIRS, default 8, meaning pairs per line (16 samples).

Function
REQ-004 SHALL implement the integer 5/3 inverse lifting.
- x[2n] = s[n] - floor((d[n-1] + d[n] + 2) / 4)
- x[2n+1] = d[n] + floor((x[2n] + x[2n+2]) / 2)
REQ-005 SHALL apply symmetric extension at line edges.
- Left edge: d[-1] = d[0].
- Right edge: x[2*LINE_PAIRS] = x[2*LINE_PAIRS-2].
REQ-006 SHALL use 18-bit signed intermediates, floor by arithmetic right shift, and truncate results to 16-bit two's complement.
REQ-007 SHALL count accepted pairs per line (0..LINE_PAIRS-1) and wrap the count to 0 after the last pair.
REQ-008 SHALL have states FIRST, RUN and FLUSH.
- FIRST, on accepted pair 0: compute x[0], latch line_address, go to RUN; no output.
- RUN, on accepted pair n (n >= 1): emit pair n-1.
- RUN, when n == LINE_PAIRS-1: also go to FLUSH.
- FLUSH, next cycle unconditionally: emit the last pair, go to FIRST.
REQ-009 SHALL have output registers with one cycle of latency after the triggering event (acceptance or FLUSH); output_valid is high for exactly one cycle per emitted pair.
REQ-010 SHALL accept wrreq in every state including FLUSH.
- In FLUSH, an accepted pair is pair 0 of the next line and is processed as in FIRST.
- The block never stalls; back-to-back lines sustain one pair per cycle.
REQ-011 SHALL hold state, counters and outputs when wrreq is low, with output_valid low; gaps of any length mid-line have no effect on results.
REQ-012 SHALL keep each emitted pair's addresses on the line latched at that line's pair 0, even while pair 0 of the next line is accepted in the same cycle.
REQ-013 SHALL ignore data_in_low, data_in_high and line_address when wrreq is low.

Reset
REQ-014 SHALL, on rst_n low at a clock edge, clear to 0 the following: output_valid, data_out_even, data_out_odd, even_address, odd_address, pair counter and all history registers; state goes to FIRST.
REQ-015 SHALL, on reset mid-line, discard the partial line with no flush output; the first pair accepted after reset is pair 0.

Structure
REQ-016 SHALL take COEF_W=16, LINE_PAIRS=8, ADDR_W=12 and the state encoding from shared package wavelet_pkg, which is also used by wavelet_queue.
REQ-017 SHALL place the REQ-004 update arithmetic (combinational) in one sub-module, inv_lift_53; the pipeline, state machine and address logic stay in inv_wavelet_queue.

Verification
REQ-018 SHALL pass these directed scenarios:
- Constant: 8 pairs low=100, high=0, line 1 -> 8 output pairs, all 100/100; addresses 12'h010/12'h011 through 12'h01E/12'h01F.
- Latency: pair 0 at cycle T, pair 1 at T+1 -> output_valid first high at T+2; pair 7 at T+7 -> last pair output at T+9.
- Lifting: low=10, high=4 constant -> interior pairs even=8, odd=12; edge pairs checked against REQ-005.
- Round trip: wavelet_queue output of {0,225,74,150,204,142,240,242,225,82,289,62,127,126,226,27} fed in -> exact original samples.
- Gaps and back-to-back: wrreq low 3 cycles mid-line, then line 2 immediately after line 1 -> identical data; pair 0 of line 2 coincides with line 1 FLUSH; 16 outputs total with correct line addresses.
- Reset: rst_n low after pair 4 -> all outputs 0 next cycle; next line starts at column 0 with no stale output.
